// File: rtl/irq_pkg.sv
// Shared types for the interrupt source controller.
package irq_pkg;
  localparam int N_IRQ_DEF  = 4;
  localparam int DATA_W_DEF = 8;

  typedef logic [$clog2(N_IRQ_DEF)-1:0] irq_id_t;

  typedef enum logic {IDLE, REQ} irq_state_e;
endpackage

// File: rtl/irq_prio_enc.sv
// Combinational priority encoder: the highest set index wins.
module irq_prio_enc #(
  parameter int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] vec,
  output logic         valid,
  output logic [W-1:0] index
);
  always_comb begin
    valid = 1'b0;
    index = '0;
    // Ascending scan, so the last hit (highest index) sticks.
    for (int k = 0; k < N; k++) begin
      if (vec[k]) begin
        valid = 1'b1;
        index = W'(k);
      end
    end
  end
endmodule

// File: rtl/irq_controller.sv
// Edge-latched interrupt source with fixed-priority req/ack grant.
// Optional ack timeout is enabled by defining IRQ_TIMEOUT_EN.
module irq_controller
  import irq_pkg::*;
#(
  parameter int N_IRQ          = N_IRQ_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int TIMEOUT_CYCLES = 16,
  localparam int ID_W          = $clog2(N_IRQ)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [N_IRQ-1:0]        irq_i,
  input  logic [N_IRQ*DATA_W-1:0] data_i,
  input  logic [N_IRQ-1:0]        mask_i,
  output logic                    req_o,
  output logic [ID_W-1:0]         id_o,
  output logic [DATA_W-1:0]       data_o,
  input  logic                    ack_i,
  output logic [N_IRQ-1:0]        pending_o,
  output logic                    timeout_o
);
  logic [N_IRQ-1:0]             irq_q, pending, rise, clr, cand;
  logic [N_IRQ-1:0][DATA_W-1:0] data_arr;
  logic                         win_vld, tmo_hit;
  logic [ID_W-1:0]              win_id;
  irq_state_e                   state;

  assign data_arr  = data_i;
  assign rise      = irq_i & ~irq_q;
  assign cand      = pending & ~mask_i;
  assign pending_o = pending;

  irq_prio_enc #(.N(N_IRQ)) u_enc (
    .vec  (cand),
    .valid(win_vld),
    .index(win_id)
  );

  always_comb begin
    clr = '0;
    if (state == REQ && ack_i) clr[id_o] = 1'b1;
  end

`ifdef IRQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt;

  // Fires on the last of TIMEOUT_CYCLES unacked REQ cycles; ack wins.
  assign tmo_hit = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt       <= '0;
      timeout_o <= 1'b0;
    end else begin
      timeout_o <= 1'b0;
      if (state == REQ && !ack_i) begin
        if (tmo_hit) begin
          cnt       <= '0;
          timeout_o <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end
`else
  assign tmo_hit   = 1'b0;
  assign timeout_o = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      irq_q   <= '0;
      pending <= '0;
      state   <= IDLE;
      req_o   <= 1'b0;
      id_o    <= '0;
      data_o  <= '0;
    end else begin
      irq_q   <= irq_i;
      pending <= (pending & ~clr) | rise;  // set wins over clear
      case (state)
        IDLE: if (win_vld) begin
          id_o   <= win_id;
          data_o <= data_arr[win_id];
          req_o  <= 1'b1;
          state  <= REQ;
        end
        REQ: if (ack_i || tmo_hit) begin
          req_o <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
